sync_updown_counter: RTL and testbench
======================================

SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter bit width (2..16).
REQ-002 Parameter: MAX_VAL, default 2**WIDTH-1, highest count value (1..2**WIDTH-1); the count range is 0..MAX_VAL.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; one step per clk edge while high.
REQ-006 up_dn  input  1  direction: 1 = up, 0 = down; sampled each edge.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 oneshot  input  1  mode: 0 = free-run with wrap, 1 = stop at terminal.
REQ-010 clr_flags  input  1  synchronous clear of sticky flags.
REQ-011 q  output  WIDTH  registered count.
REQ-012 tc  output  1  combinational terminal-count indication.
REQ-013 wrap  output  1  registered one-cycle pulse.
REQ-014 done  output  1  registered; high while the FSM is in DONE.
REQ-015 ovf  output  1  registered sticky up-wrap flag.
REQ-016 unf  output  1  registered sticky down-wrap flag.

Function
REQ-017 The FSM SHALL have exactly two states, COUNT and DONE; done SHALL be 1 only in DONE.
REQ-018 Edge priority SHALL be load > count step > hold.
REQ-019 On load, q SHALL take min(load_val, MAX_VAL) at that edge; the FSM SHALL go to COUNT; wrap SHALL be 0 next cycle; flags SHALL be unaffected.
REQ-020 A count step SHALL occur when en=1, load=0 and state=COUNT.
REQ-021 In DONE, q SHALL hold regardless of en, up_dn or oneshot; only load or reset SHALL leave DONE.
REQ-022 tc SHALL be (up_dn=1 and q=MAX_VAL) or (up_dn=0 and q=0), independent of en and state.
REQ-023 Step with tc=0: q SHALL become q+1 (up) or q-1 (down), with no flag or wrap activity.
REQ-024 Step with tc=1 and oneshot=0, up: q SHALL become 0, wrap SHALL pulse 1 next cycle, and ovf SHALL set.
REQ-025 Step with tc=1 and oneshot=0, down: q SHALL become MAX_VAL, wrap SHALL pulse 1 next cycle, and unf SHALL set.
REQ-026 Step with tc=1 and oneshot=1: q SHALL hold, the FSM SHALL go to DONE, wrap SHALL stay 0, and flags SHALL be unaffected.
REQ-027 wrap SHALL be high for exactly one cycle per wrap event; back-to-back wraps (e.g. MAX_VAL=1 free-run) SHALL keep wrap high on consecutive cycles.
REQ-028 clr_flags SHALL clear ovf and unf at the edge; if a wrap sets a flag at the same edge, set SHALL win.
REQ-029 A direction change SHALL take effect on the same edge it is sampled, with no idle cycle.
REQ-030 Arithmetic SHALL be WIDTH bits with explicit wrap to 0 or MAX_VAL; q SHALL never exceed MAX_VAL.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, force q=0, state=COUNT, wrap=0, done=0, ovf=0 and unf=0.
REQ-032 Reset asserted mid-count or in DONE SHALL abort the operation; the first step after deassertion SHALL start from q=0.
REQ-033 Deassertion is synchronous to clk externally; the block SHALL add no synchronizer.

Verification
REQ-034 WIDTH=4, MAX_VAL=9, oneshot=0, up, en=1 for 12 clocks from reset -> q = 1..9,0,1,2; wrap high only the cycle after 9->0; ovf=1.
REQ-035 MAX_VAL=9, load 3, down, oneshot=1, en=1 -> q = 2,1,0 then holds 0; done=1; wrap=0; unf=0; then load 5 -> done=0 and q=5.
REQ-036 MAX_VAL=9, load_val=14 with load=1 and en=1 -> q=9; next up step with oneshot=0 -> q=0 and wrap pulses.
REQ-037 Free-run at q=MAX_VAL with clr_flags=1 and up step on the same edge -> ovf=1; clr_flags alone next edge -> ovf=0.
REQ-038 Assert rst_n=0 between clock edges while q=6 in COUNT -> q=0 immediately; also in DONE -> done=0 immediately.
REQ-039 Alternate up_dn each cycle from q=0, en=1, MAX_VAL=15 -> q = 15(unf),0(ovf),15,...; tc tracks the direction combinationally.

Source files
------------

// File: rtl/sync_updown_counter_if.sv
// Bus between a controller and the up/down counter: control strobes in,
// count value and status flags out.
interface sync_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             oneshot;
  logic             clr_flags;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             done;
  logic             ovf;
  logic             unf;

  modport master (
    output en, up_dn, load, load_val, oneshot, clr_flags,
    input  q, tc, wrap, done, ovf, unf
  );

  modport slave (
    input  en, up_dn, load, load_val, oneshot, clr_flags,
    output q, tc, wrap, done, ovf, unf
  );
endinterface

// File: rtl/sync_updown_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with parallel load, free-run or
// one-shot terminal behaviour, wrap pulse and sticky wrap-direction flags.
module sync_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input logic                  clk,
  input logic                  rst_n,
  sync_updown_counter_if.slave cnt
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  typedef enum logic {
    COUNT = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap;
  logic             wrap_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic             unf;
  logic             unf_nxt;
  logic             tc;

  // Loaded values above the count range are clamped so q never leaves 0..MAX_VAL.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  assign tc = cnt.up_dn ? (q == MAX_Q) : (q == '0);

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    wrap_nxt  = 1'b0;
    ovf_nxt   = ovf & ~cnt.clr_flags;
    unf_nxt   = unf & ~cnt.clr_flags;
    if (cnt.load) begin
      q_nxt     = sat_load(cnt.load_val);
      state_nxt = COUNT;
    end else if (cnt.en && (state == COUNT)) begin
      if (!tc) begin
        q_nxt = cnt.up_dn ? (q + WIDTH'(1)) : (q - WIDTH'(1));
      end else if (!cnt.oneshot) begin
        // Flag set is applied after the clear term, so a same-edge wrap wins.
        wrap_nxt = 1'b1;
        if (cnt.up_dn) begin
          q_nxt   = '0;
          ovf_nxt = 1'b1;
        end else begin
          q_nxt   = MAX_Q;
          unf_nxt = 1'b1;
        end
      end else begin
        state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COUNT;
      q     <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      wrap  <= wrap_nxt;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end

  assign cnt.q    = q;
  assign cnt.tc   = tc;
  assign cnt.wrap = wrap;
  assign cnt.done = (state == DONE);
  assign cnt.ovf  = ovf;
  assign cnt.unf  = unf;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench: a MAX_VAL=9 counter for load/one-shot/flag/reset cases and
// a full-range MAX_VAL=15 counter for alternating-direction wrapping.
module tb_sync_updown_counter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  sync_updown_counter_if #(.WIDTH(4)) a9 ();
  sync_updown_counter_if #(.WIDTH(4)) b15 ();

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (a9)
  );

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(15)) dut15 (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (b15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int want);
    n_chk++;
    if (obs != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b1;
    a9.en = 0; a9.up_dn = 0; a9.load = 0; a9.load_val = '0; a9.oneshot = 0; a9.clr_flags = 0;
    b15.en = 0; b15.up_dn = 0; b15.load = 0; b15.load_val = '0; b15.oneshot = 0; b15.clr_flags = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q", a9.q, 0);
    chk("rst_done", a9.done, 0);
    chk("rst_wrap", a9.wrap, 0);
    chk("rst_ovf", a9.ovf, 0);
    chk("rst_unf", a9.unf, 0);
    tick();
    tick();
    chk("rst_hold_q", a9.q, 0);

    // Free-run up count from reset, wrap after 9.
    a9.en = 1; a9.up_dn = 1;
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 10) chk("up_tc_at9", a9.tc, 1);
      tick();
      chk($sformatf("up_q%0d", i), a9.q, i % 10);
      chk($sformatf("up_wrap%0d", i), a9.wrap, (i == 10) ? 1 : 0);
    end
    chk("up_ovf", a9.ovf, 1);
    chk("up_unf", a9.unf, 0);

    // Load preserves flags; clear and wrap on the same edge: set wins.
    a9.load = 1; a9.load_val = 4'd9;
    tick();
    chk("ld9_q", a9.q, 9);
    chk("ld9_ovf", a9.ovf, 1);
    a9.load = 0; a9.clr_flags = 1;
    tick();
    chk("clrwin_q", a9.q, 0);
    chk("clrwin_wrap", a9.wrap, 1);
    chk("clrwin_ovf", a9.ovf, 1);
    a9.en = 0;
    tick();
    chk("clr_ovf", a9.ovf, 0);
    chk("clr_wrap", a9.wrap, 0);
    a9.clr_flags = 0;

    // Down wrap from 0 in free-run.
    a9.en = 1; a9.up_dn = 0;
    tick();
    chk("dn_q", a9.q, 9);
    chk("dn_unf", a9.unf, 1);
    chk("dn_wrap", a9.wrap, 1);
    tick();
    chk("dn_q8", a9.q, 8);
    chk("dn_wrap_off", a9.wrap, 0);
    a9.en = 0; a9.clr_flags = 1;
    tick();
    chk("clr_unf", a9.unf, 0);
    a9.clr_flags = 0;

    // Over-range load clamps, then up wrap.
    a9.load = 1; a9.load_val = 4'd14; a9.en = 1; a9.up_dn = 1;
    tick();
    chk("sat_q", a9.q, 9);
    chk("sat_wrap", a9.wrap, 0);
    a9.load = 0;
    tick();
    chk("sat_step_q", a9.q, 0);
    chk("sat_step_wrap", a9.wrap, 1);

    // One-shot down from 3 into DONE, then load leaves DONE.
    a9.load = 1; a9.load_val = 4'd3; a9.up_dn = 0; a9.oneshot = 1;
    tick();
    chk("os_ld_q", a9.q, 3);
    a9.load = 0;
    for (int i = 2; i >= 0; i--) begin
      tick();
      chk($sformatf("os_q%0d", i), a9.q, i);
      chk($sformatf("os_done%0d", i), a9.done, 0);
    end
    tick();
    chk("os_term_q", a9.q, 0);
    chk("os_done", a9.done, 1);
    chk("os_wrap", a9.wrap, 0);
    chk("os_unf", a9.unf, 0);
    a9.up_dn = 1; a9.oneshot = 0;
    tick();
    chk("done_hold_q", a9.q, 0);
    chk("done_hold", a9.done, 1);
    a9.load = 1; a9.load_val = 4'd5;
    tick();
    chk("exit_q", a9.q, 5);
    chk("exit_done", a9.done, 0);
    a9.load = 0; a9.en = 0;
    chk("tc_mid_up", a9.tc, 0);
    a9.up_dn = 0;
    #1;
    chk("tc_mid_dn", a9.tc, 0);

    // Asynchronous reset mid-count.
    a9.load = 1; a9.load_val = 4'd6;
    tick();
    chk("pre_rst_q", a9.q, 6);
    a9.load = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", a9.q, 0);
    tick();
    rst_n = 1'b1;

    // Asynchronous reset while in DONE.
    a9.oneshot = 1; a9.up_dn = 1; a9.load = 1; a9.load_val = 4'd9; a9.en = 1;
    tick();
    a9.load = 0;
    tick();
    chk("pre_rst_done", a9.done, 1);
    a9.en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", a9.done, 0);
    chk("arst_done_q", a9.q, 0);
    tick();
    rst_n = 1'b1;
    a9.oneshot = 0; a9.en = 1;
    tick();
    chk("post_rst_q", a9.q, 1);
    a9.en = 0;

    // Alternating direction on a full-range counter.
    b15.en = 1;
    for (int i = 0; i < 6; i++) begin
      b15.up_dn = (i % 2 == 1);
      #1;
      chk($sformatf("alt_tc%0d", i), b15.tc, 1);
      tick();
      chk($sformatf("alt_q%0d", i), b15.q, (i % 2 == 1) ? 0 : 15);
      chk($sformatf("alt_wrap%0d", i), b15.wrap, 1);
    end
    chk("alt_ovf", b15.ovf, 1);
    chk("alt_unf", b15.unf, 1);
    b15.en = 0;
    tick();
    chk("alt_wrap_end", b15.wrap, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
